mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 16, data word width in bits.
REQ-003 Parameter WAIT_CYCLES, default 2, number of wait states inserted before each access (range 0..15).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 initiate_op  input  1  request from controller, held high until op_complete is seen.
REQ-007 read_write  input  1  1 = read, 0 = write; sampled with the request.
REQ-008 addr  input  ADDR_W  word address (MAR side).
REQ-009 data_in  input  DATA_W  write data (MDR side).
REQ-010 data_out  output  DATA_W  read data; valid while op_complete=1 after a read.
REQ-011 op_complete  output  1  completion, level, four-phase handshake.
REQ-012 busy  output  1  high in WAIT and DONE.

Function
REQ-013 Storage SHALL be 2^ADDR_W words of DATA_W bits, synchronous write, registered read.
REQ-014 FSM SHALL have states IDLE, WAIT, DONE.
REQ-015 IDLE: when initiate_op=1 at an edge, latch addr, data_in and read_write, load counter cnt<=WAIT_CYCLES, and go to WAIT.
REQ-016 WAIT with cnt!=0: cnt<=cnt-1 and stay in WAIT.
REQ-017 WAIT with cnt==0: perform the access, set op_complete<=1, and go to DONE.
REQ-018 The WAIT access SHALL be: write -> mem[latched addr]<=latched data; read -> data_out<=mem[latched addr].
REQ-019 Latency: op_complete SHALL first be high after accept edge + WAIT_CYCLES+1 edges (3 edges for the default).
REQ-020 DONE: op_complete and data_out held stable; when initiate_op=0 at an edge, op_complete<=0 and go to IDLE.
REQ-021 A new request SHALL be accepted only from IDLE, so initiate_op must be sampled low at least once between transactions.
REQ-022 Changes on addr, data_in or read_write after the accept edge SHALL be ignored until the next accept.
REQ-023 If initiate_op falls during WAIT, the transaction SHALL still complete, with op_complete high for exactly one cycle before IDLE.
REQ-024 A write SHALL leave data_out unchanged.
REQ-025 busy SHALL be decoded from state (state != IDLE), with no extra register latency.
REQ-026 The counter SHALL be 4 bits wide and SHALL never underflow; WAIT_CYCLES=0 gives a single WAIT cycle.

Reset
REQ-027 rst=1 at an edge SHALL force: state IDLE, op_complete=0, busy=0, data_out=0, cnt=0.
REQ-028 rst has priority over all other inputs.
REQ-029 rst during WAIT SHALL abort the transaction, with no memory write performed.
REQ-030 Memory contents SHALL NOT be cleared by rst.

Verification
REQ-031 Write 16'hA5A5 to addr 8'h10 with WAIT_CYCLES=2 -> op_complete high on the 3rd edge after accept, busy high throughout, op_complete low one edge after initiate_op drops.
REQ-032 Read addr 8'h10 after REQ-031 -> data_out=16'hA5A5 while op_complete=1.
REQ-033 Hold initiate_op high through DONE for 5 cycles -> op_complete stays 1, no second access occurs, and data_out is stable.
REQ-034 Change addr and data_in on the cycle after accept -> the originally latched address and data are used.
REQ-035 Assert rst one cycle after accepting a write to 8'h20 -> outputs return to reset values and a later read of 8'h20 returns its prior contents.
REQ-036 Build with WAIT_CYCLES=0 and issue back-to-back write/read, with initiate_op low for one cycle between -> each op_complete is seen one edge after accept and data matches.

Source files
------------

// File: rtl/mem_responder.sv
// Wait-stated single-port memory responder with a four-phase initiate/complete handshake.
// Request fields are captured on acceptance; the access happens once the wait counter expires.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              initiate_op,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              op_complete,
  output logic              busy
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rd_r;
  logic [DATA_W-1:0] data_out_r;
  logic              op_complete_r;
  logic              accept_s;
  logic              access_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Next-state, counter and strobe decode for the handshake FSM
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    access_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (initiate_op) begin
          state_s  = ST_WAIT;
          cnt_s    = WAIT_INIT;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // The counter parks at zero on the access cycle, so it can never wrap
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          access_s = 1'b1;
          state_s  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!initiate_op) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      op_complete_r <= 1'b0;
      data_out_r    <= '0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      op_complete_r <= (state_s == ST_DONE);
      if (access_s && rd_r) begin
        data_out_r <= mem_r[addr_r];
      end
    end
  end

  // Request capture: later changes on the bus are ignored until the next accept
  always_ff @(posedge clk) begin
    if (!rst && accept_s) begin
      addr_r  <= addr;
      wdata_r <= data_in;
      rd_r    <= read_write;
    end
  end

  // Storage is never cleared; an aborted transaction never reaches the access cycle
  always_ff @(posedge clk) begin
    if (!rst && access_s && !rd_r) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

  assign data_out    = data_out_r;
  assign op_complete = op_complete_r;
  assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a default instance (2 wait states) and a zero-wait instance.
// The driver pushes the expected data_out per transaction; a monitor pops it on each op_complete rise.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        init0, init1;
  logic        rw_in;
  logic [7:0]  addr_in;
  logic [15:0] din;
  logic [15:0] dout0, dout1;
  logic        oc0, oc1, busy0, busy1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        oc0_q = 1'b0;
  logic        oc1_q = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .initiate_op(init0), .read_write(rw_in), .addr(addr_in),
    .data_in(din), .data_out(dout0), .op_complete(oc0), .busy(busy0)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .initiate_op(init1), .read_write(rw_in), .addr(addr_in),
    .data_in(din), .data_out(dout1), .op_complete(oc1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic oc_m(input int sel);
    return (sel != 0) ? oc1 : oc0;
  endfunction

  function automatic logic busy_m(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction

  function automatic logic [15:0] dout_m(input int sel);
    return (sel != 0) ? dout1 : dout0;
  endfunction

  task automatic set_init(input int sel, input logic v);
    if (sel != 0) init1 = v;
    else init0 = v;
  endtask

  // Monitor: compare data_out on every rising op_complete against the scoreboard
  always @(negedge clk) begin
    if (oc0 && !oc0_q) begin
      if (q0.size() == 0) begin
        total_cnt++;
        $display("FAIL dut0_unexpected_complete: got completion expected none at %0t", $time);
      end else begin
        check("dut0_data_out", dout0, q0.pop_front());
      end
    end
    if (oc1 && !oc1_q) begin
      if (q1.size() == 0) begin
        total_cnt++;
        $display("FAIL dut1_unexpected_complete: got completion expected none at %0t", $time);
      end else begin
        check("dut1_data_out", dout1, q1.pop_front());
      end
    end
    oc0_q = oc0;
    oc1_q = oc1;
  end

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_op(input int sel, input logic rw, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] exp_out, input int hold, input bit perturb,
                       input bit drop_early);
    int lat;
    int exp_lat;
    bit busy_bad;
    exp_lat  = (sel != 0) ? 1 : 3;
    busy_bad = 1'b0;
    if (sel != 0) q1.push_back(exp_out);
    else q0.push_back(exp_out);
    rw_in   = rw;
    addr_in = a;
    din     = d;
    set_init(sel, 1'b1);
    @(negedge clk);
    check("busy_after_accept", busy_m(sel), 1'b1);
    if (perturb) begin
      addr_in = ~a;
      din     = ~d;
      rw_in   = ~rw;
    end
    if (drop_early) set_init(sel, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!busy_m(sel)) busy_bad = 1'b1;
    end while (!oc_m(sel) && lat < 16);
    check("latency", lat, exp_lat);
    check("busy_throughout", busy_bad, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_op_complete", oc_m(sel), 1'b1);
      check("hold_data_out", dout_m(sel), exp_out);
    end
    set_init(sel, 1'b0);
    @(negedge clk);
    check("op_complete_dropped", oc_m(sel), 1'b0);
    check("busy_dropped", busy_m(sel), 1'b0);
  endtask

  initial begin
    rst = 1'b1; init0 = 1'b0; init1 = 1'b0;
    rw_in = 1'b0; addr_in = 8'h00; din = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_op_complete0", oc0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_data_out0", dout0, 16'h0000);
    check("rst_op_complete1", oc1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_data_out1", dout1, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // basic write/read, hold in DONE, ignored bus changes, early drop
    do_op(0, 1'b0, 8'h10, 16'hA5A5, 16'h0000, 0, 1'b0, 1'b0);
    do_op(0, 1'b1, 8'h10, 16'h0000, 16'hA5A5, 0, 1'b0, 1'b0);
    do_op(0, 1'b0, 8'h11, 16'h1111, 16'hA5A5, 5, 1'b0, 1'b0);
    do_op(0, 1'b1, 8'h11, 16'h0000, 16'h1111, 5, 1'b0, 1'b0);
    do_op(0, 1'b0, 8'hCF, 16'h5555, 16'h1111, 0, 1'b0, 1'b0);
    do_op(0, 1'b0, 8'h30, 16'hC3C3, 16'h1111, 0, 1'b1, 1'b0);
    do_op(0, 1'b1, 8'h30, 16'h0000, 16'hC3C3, 0, 1'b0, 1'b0);
    do_op(0, 1'b1, 8'hCF, 16'h0000, 16'h5555, 0, 1'b0, 1'b0);
    do_op(0, 1'b0, 8'h40, 16'h4040, 16'h5555, 0, 1'b0, 1'b1);
    do_op(0, 1'b1, 8'h40, 16'h0000, 16'h4040, 0, 1'b0, 1'b1);
    do_op(0, 1'b0, 8'h20, 16'h1234, 16'h4040, 0, 1'b0, 1'b0);

    // reset one cycle after accepting a write to 8'h20 aborts it
    rw_in = 1'b0; addr_in = 8'h20; din = 16'hBEEF; init0 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_op_complete", oc0, 1'b0);
    check("abort_busy", busy0, 1'b0);
    check("abort_data_out", dout0, 16'h0000);
    rst = 1'b0; init0 = 1'b0;
    @(negedge clk);
    do_op(0, 1'b1, 8'h20, 16'h0000, 16'h1234, 0, 1'b0, 1'b0);

    // zero-wait instance, back-to-back with one idle cycle between
    do_op(1, 1'b0, 8'h05, 16'h0F0F, 16'h0000, 0, 1'b0, 1'b0);
    do_op(1, 1'b1, 8'h05, 16'h0000, 16'h0F0F, 0, 1'b0, 1'b0);
    do_op(1, 1'b0, 8'h06, 16'hF0F0, 16'h0F0F, 0, 1'b0, 1'b0);
    do_op(1, 1'b1, 8'h06, 16'h0000, 16'hF0F0, 0, 1'b0, 1'b0);

    @(negedge clk);
    check("dut0_queue_drained", q0.size(), 0);
    check("dut1_queue_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
